// File: rtl/aes256_key_expander_if.sv
// Key-load / round-key read bundle for aes256_key_expander.
// The master side loads cipher keys and issues round-key reads.
// The slave side is the expander itself.
interface aes256_key_expander_if;
    logic         v_i;
    logic [255:0] key_i;
    logic         ready_o;
    logic         busy_o;
    logic         done_o;
    logic         rk_v_i;
    logic [3:0]   rk_idx_i;
    logic         dec_i;
    logic         rk_v_o;
    logic [127:0] rk_o;

    modport master (
        output v_i, key_i, rk_v_i, rk_idx_i, dec_i,
        input  ready_o, busy_o, done_o, rk_v_o, rk_o
    );

    modport slave (
        input  v_i, key_i, rk_v_i, rk_idx_i, dec_i,
        output ready_o, busy_o, done_o, rk_v_o, rk_o
    );
endinterface

// File: rtl/aes256_key_expander.sv
// AES-256 key schedule engine.
// It expands one 256-bit key into round keys RK0..RK14 using one round_key
// step per cycle, seven steps in all. The keys are held in a register file
// and served through a registered read port with 1-cycle latency.
// Optional macro AES_KEY_EXP_DEC_ORDER_EN: when defined, dec_i=1 reads the
// keys in reverse order (eff_idx = 14 - rk_idx_i).
module aes256_key_expander (
    input  logic                         clk_i,
    input  logic                         reset_i,
    aes256_key_expander_if.slave         kx_io
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXPAND = 2'd1, S_DONE = 2'd2} state_t;

    // AES forward S-box; byte x is at bit offset (255-x)*8.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One AES-256 expansion step: eight new words from the previous eight.
    // Word j of a 256-bit state sits at bits [32j+31:32j]; the low half
    // becomes RK(2r) and the high half RK(2r+1).
    function automatic logic [255:0] round_key(input logic [255:0] ks, input logic [4:0] r);
        logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
        logic [31:0] rot;
        logic [7:0]  rcon;
        rcon = 8'h01 << (r - 5'd1);
        rot  = {ks[247:224], ks[255:248]};
        w0   = ks[31:0]    ^ sub_word(rot) ^ {rcon, 24'h000000};
        w1   = ks[63:32]   ^ w0;
        w2   = ks[95:64]   ^ w1;
        w3   = ks[127:96]  ^ w2;
        w4   = ks[159:128] ^ sub_word(w3);
        w5   = ks[191:160] ^ w4;
        w6   = ks[223:192] ^ w5;
        w7   = ks[255:224] ^ w6;
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    state_t         state_q, state_d;
    logic [2:0]     r_q, r_d;
    logic [255:0]   key_state_q;
    logic [127:0]   rk_mem_q [0:14];
    logic           rk_v_q;
    logic [127:0]   rk_q;

    logic           ready, busy, done;
    logic           accept;
    logic [255:0]   res;
    logic [3:0]     even_idx;
    logic [3:0]     eff_idx;
    logic           rd_ok;

    assign accept   = kx_io.v_i & ready;
    assign res      = round_key(key_state_q, {2'b00, r_q});
    assign even_idx = {r_q, 1'b0};
    assign rd_ok    = kx_io.rk_v_i & done & (kx_io.rk_idx_i <= 4'd14);

`ifdef AES_KEY_EXP_DEC_ORDER_EN
    assign eff_idx = kx_io.dec_i ? (4'd14 - kx_io.rk_idx_i) : kx_io.rk_idx_i;
`else
    logic unused_dec;
    assign unused_dec = kx_io.dec_i;
    assign eff_idx    = kx_io.rk_idx_i;
`endif

    // FSM state and iteration counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            r_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    // Next-state logic: accept a key from IDLE/DONE, run seven iterations.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = S_EXPAND;
                    r_d     = 3'd1;
                end
            end
            S_EXPAND: begin
                if (r_q == 3'd7) begin
                    state_d = S_DONE;
                end else begin
                    r_d = r_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                r_d     = 3'd0;
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            S_IDLE:   ready = 1'b1;
            S_EXPAND: busy  = 1'b1;
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default:  ready = 1'b0;
        endcase
    end

    // Key state and round-key storage; data only, so no reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (accept) begin
                key_state_q <= kx_io.key_i;
                rk_mem_q[0] <= kx_io.key_i[127:0];
                rk_mem_q[1] <= kx_io.key_i[255:128];
            end else if (state_q == S_EXPAND) begin
                key_state_q        <= res;
                rk_mem_q[even_idx] <= res[127:0];
                // RK15 does not exist: the last iteration keeps only its low half.
                if (r_q != 3'd7) begin
                    rk_mem_q[even_idx + 4'd1] <= res[255:128];
                end
            end
        end
    end

    // Registered read port; rk_o holds its value when no valid read occurs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rk_v_q <= 1'b0;
            rk_q   <= 128'h0;
        end else begin
            rk_v_q <= rd_ok;
            if (rd_ok) begin
                rk_q <= rk_mem_q[eff_idx];
            end
        end
    end

    assign kx_io.ready_o = ready;
    assign kx_io.busy_o  = busy;
    assign kx_io.done_o  = done;
    assign kx_io.rk_v_o  = rk_v_q;
    assign kx_io.rk_o    = rk_q;

endmodule

// File: tb/tb_aes256_key_expander.sv
// Testbench for aes256_key_expander: golden key schedule built from an
// algebraic S-box (GF(2^8) inverse + affine map), read scoreboard queue.
module tb_aes256_key_expander;

`ifdef AES_KEY_EXP_DEC_ORDER_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes256_key_expander_if kx();

    aes256_key_expander dut (
        .clk_i   (clk),
        .reset_i (rst),
        .kx_io   (kx.slave)
    );

    typedef struct {
        string        name;
        logic         v;
        logic [127:0] rk;
    } sb_item_t;

    typedef struct {
        logic [3:0] idx;
        logic       dec;
        logic       exp_v;
        int         exp_slot;
    } rd_vec_t;

    sb_item_t     sb[$];
    rd_vec_t      vecs[$];
    int           total = 0;
    int           bad   = 0;
    logic [127:0] last_rk = 128'h0;
    logic [7:0]   sb_model [0:255];
    logic [127:0] gold [0:14];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] xb = 8'(x);
            for (int y = 1; y < 256; y++) begin
                if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb_model[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] msub(input logic [31:0] w);
        return {sb_model[w[31:24]], sb_model[w[23:16]], sb_model[w[15:8]], sb_model[w[7:0]]};
    endfunction

    // Classic word-indexed key expansion over w[0..59], then split into RKs.
    task automatic build_gold(input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [7:0]  rc;
        logic [31:0] t;
        for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = msub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = msub(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++) gold[k] = {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]};
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: sample just after the edge, compare any due read, drop pulses.
    task automatic tick();
        sb_item_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.name, "_v"}, {127'h0, kx.rk_v_o}, {127'h0, e.v});
            chk({e.name, "_rk"}, kx.rk_o, e.rk);
        end
        kx.v_i    = 1'b0;
        kx.rk_v_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx, input logic dec, input logic ev,
                      input logic [127:0] erk, input string nm);
        sb_item_t e;
        kx.rk_v_i    = 1'b1;
        kx.rk_idx_i  = idx;
        kx.dec_i     = dec;
        e.name = nm;
        e.v    = ev;
        e.rk   = ev ? erk : last_rk;
        if (ev) last_rk = erk;
        sb.push_back(e);
        tick();
    endtask

    task automatic accept(input logic [255:0] key);
        kx.v_i   = 1'b1;
        kx.key_i = key;
        tick();
    endtask

    // Seven cycles after accept: reads are refused, stray v_i pulses ignored.
    task automatic wait_done(input string tag);
        for (int i = 1; i <= 7; i++) begin
            if (i == 2 || i == 4) begin
                kx.v_i   = 1'b1;
                kx.key_i = {8{32'hdeadbeef}};
            end
            rd(4'(i), 1'b0, 1'b0, 128'h0, $sformatf("%s_exp_rd%0d", tag, i));
            chk($sformatf("%s_done_e%0d", tag, i), {127'h0, kx.done_o}, {127'h0, (i == 7)});
            if (i == 1 || i == 7) begin
                chk($sformatf("%s_ready_e%0d", tag, i), {127'h0, kx.ready_o}, {127'h0, (i == 7)});
                chk($sformatf("%s_busy_e%0d", tag, i), {127'h0, kx.busy_o}, {127'h0, (i != 7)});
            end
        end
    endtask

    task automatic run_table(input string tag);
        foreach (vecs[n]) begin
            rd(vecs[n].idx, vecs[n].dec, vecs[n].exp_v,
               vecs[n].exp_v ? gold[vecs[n].exp_slot] : 128'h0,
               $sformatf("%s_i%0d_d%0d", tag, vecs[n].idx, vecs[n].dec));
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, {127'h0, kx.ready_o}, 128'h1);
        chk({tag, "_busy"},  {127'h0, kx.busy_o},  128'h0);
        chk({tag, "_done"},  {127'h0, kx.done_o},  128'h0);
        chk({tag, "_rkv"},   {127'h0, kx.rk_v_o},  128'h0);
        chk({tag, "_rk"},    kx.rk_o,              128'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] k_fips, k3, k5, k6;
        k_fips = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        k3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        k5 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        k6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

        kx.v_i = 1'b0; kx.key_i = '0; kx.rk_v_i = 1'b0; kx.rk_idx_i = 4'd0; kx.dec_i = 1'b0;

        // Read vector table: all indices, illegal 15, reverse-order reads.
        for (int i = 0; i < 15; i++) vecs.push_back('{4'(i), 1'b0, 1'b1, i});
        vecs.push_back('{4'd15, 1'b0, 1'b0, 0});
        vecs.push_back('{4'd0,  1'b1, 1'b1, DEC_EN ? 14 : 0});
        vecs.push_back('{4'd14, 1'b1, 1'b1, DEC_EN ? 0 : 14});
        vecs.push_back('{4'd3,  1'b1, 1'b1, DEC_EN ? 11 : 3});
        vecs.push_back('{4'd15, 1'b1, 1'b0, 0});

        build_sbox();

        tick();
        tick();
        chk_reset_state("rst");
        rst = 1'b0;
        rd(4'd0, 1'b0, 1'b0, 128'h0, "idle_rd");

        // Zero key.
        build_gold(256'h0);
        accept(256'h0);
        chk("zk_done_e0", {127'h0, kx.done_o}, 128'h0);
        wait_done("zk");
        run_table("zk");
        rd(4'd2, 1'b0, 1'b1, 128'h62636363626363636263636362636363, "zk_rk2_kat");
        rd(4'd3, 1'b0, 1'b1, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb, "zk_rk3_kat");
        rd(4'd0, 1'b0, 1'b1, 128'h0, "zk_rk0_zero");

        // FIPS-197 key, loaded straight from DONE.
        build_gold(k_fips);
        accept(k_fips);
        wait_done("fk");
        run_table("fk");
        rd(4'd0, 1'b0, 1'b1, k_fips[127:0], "fk_rk0_key");
        rd(4'd1, 1'b0, 1'b1, k_fips[255:128], "fk_rk1_key");

        // Reload in DONE while reading RK5: read returns the old RK5.
        kx.v_i   = 1'b1;
        kx.key_i = k3;
        rd(4'd5, 1'b0, 1'b1, gold[5], "reload_old_rk5");
        chk("reload_done_fall", {127'h0, kx.done_o}, 128'h0);
        build_gold(k3);
        wait_done("k3");
        run_table("k3");

        // Reset in the middle of expansion.
        accept(k5);
        tick();
        tick();
        rst = 1'b1;
        tick();
        last_rk = 128'h0;
        chk_reset_state("midrst");
        rst = 1'b0;
        rd(4'd2, 1'b0, 1'b0, 128'h0, "midrst_rd");
        build_gold(k6);
        accept(k6);
        wait_done("k6");
        run_table("k6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
